// File: rtl/adc_dac_averager.sv
// Moving-average filter between the ADC receiver and the DAC driver: keeps a
// 2^LOG2_TAPS-tap window of ADC samples and hands the scaled mean to the DAC between frames.
module adc_dac_averager #(
    parameter int unsigned SAMPLE_WIDTH = 9,
    parameter int unsigned DAC_WIDTH    = 12,
    parameter int unsigned LOG2_TAPS    = 3
) (
    input  logic                    dacSerialClock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] adcSample,
    input  logic                    adcSampleValid,
    input  logic                    syncDAC,
    input  logic                    clearOverrun,
    output logic [DAC_WIDTH-1:0]    dataDAC,
    output logic                    dataUpdated,
    output logic                    overrun
);

    localparam int unsigned TAPS      = 1 << LOG2_TAPS;
    localparam int unsigned SUM_WIDTH = SAMPLE_WIDTH + LOG2_TAPS;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, PENDING} state_t;

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] sampleBuf [TAPS];
    logic [LOG2_TAPS-1:0]    wrPtr;
    logic [SUM_WIDTH-1:0]    sum;
    logic [SAMPLE_WIDTH-1:0] captured;
    logic [SAMPLE_WIDTH-1:0] avg;
    logic [DAC_WIDTH-1:0]    scaled;
    logic [DAC_WIDTH-1:0]    result;

    assign avg = sum[SUM_WIDTH-1 -: SAMPLE_WIDTH];

    // Repeating the average's bits from the MSB down maps 0 -> 0 and full scale -> full scale.
    always_comb begin
        scaled = '0;
        for (int unsigned i = 0; i < DAC_WIDTH; i++) begin
            scaled[DAC_WIDTH-1-i] = avg[SAMPLE_WIDTH-1-(i % SAMPLE_WIDTH)];
        end
    end

    always_ff @(posedge dacSerialClock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wrPtr       <= '0;
            sum         <= '0;
            captured    <= '0;
            result      <= '0;
            dataDAC     <= '0;
            dataUpdated <= 1'b0;
            overrun     <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                sampleBuf[i] <= '0;
            end
        end else begin
            dataUpdated <= 1'b0;

            // A drop outranks a simultaneous clear.
            if (adcSampleValid && (state == ACCUM || state == SCALE)) begin
                overrun <= 1'b1;
            end else if (clearOverrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (adcSampleValid) begin
                        captured <= adcSample;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum              <= sum + SUM_WIDTH'(captured) - SUM_WIDTH'(sampleBuf[wrPtr]);
                    sampleBuf[wrPtr] <= captured;
                    wrPtr            <= wrPtr + 1'b1;
                    state            <= SCALE;
                end
                SCALE: begin
                    result <= scaled;
                    state  <= PENDING;
                end
                PENDING: begin
                    // A fresh sample supersedes the waiting result, even if the DAC is idle now.
                    if (adcSampleValid) begin
                        captured <= adcSample;
                        state    <= ACCUM;
                    end else if (syncDAC) begin
                        dataDAC     <= result;
                        dataUpdated <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_dac_averager.sv
// Self-checking bench for adc_dac_averager: a window model predicts each DAC word,
// a negedge monitor pops the scoreboard on every dataUpdated pulse.
`timescale 1ns/1ps
module tb_adc_dac_averager;

    logic        dacSerialClock = 1'b0;
    logic        reset          = 1'b1;
    logic [8:0]  adcSample      = '0;
    logic        adcSampleValid = 1'b0;
    logic        syncDAC        = 1'b1;
    logic        clearOverrun   = 1'b0;
    logic [11:0] dataDAC;
    logic        dataUpdated;
    logic        overrun;

    int compared   = 0;
    int mismatched = 0;

    logic [11:0] expQ [$];
    logic [11:0] monExp;
    logic [8:0]  mBuf [8];
    int unsigned mPtr = 0;
    int unsigned mSum = 0;

    adc_dac_averager #(.SAMPLE_WIDTH(9), .DAC_WIDTH(12), .LOG2_TAPS(3)) dut (
        .dacSerialClock(dacSerialClock),
        .reset(reset),
        .adcSample(adcSample),
        .adcSampleValid(adcSampleValid),
        .syncDAC(syncDAC),
        .clearOverrun(clearOverrun),
        .dataDAC(dataDAC),
        .dataUpdated(dataUpdated),
        .overrun(overrun)
    );

    always #5 dacSerialClock = ~dacSerialClock;

    function automatic logic [11:0] modelPush(input logic [8:0] s);
        int unsigned a;
        mSum = mSum + s - mBuf[mPtr];
        mBuf[mPtr] = s;
        mPtr = (mPtr + 1) % 8;
        a = mSum / 8;
        return 12'(a * 8 + a / 64);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mBuf[i] = '0;
        mPtr = 0;
        mSum = 0;
        expQ.delete();
    endtask

    task automatic tick();
        @(negedge dacSerialClock);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulseValid(input logic [8:0] s);
        adcSample      = s;
        adcSampleValid = 1'b1;
        tick();
        adcSampleValid = 1'b0;
    endtask

    always @(negedge dacSerialClock) begin
        if (!reset && dataUpdated === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_update: dataDAC=%0d, no update expected", dataDAC);
            end else begin
                monExp = expQ.pop_front();
                if (dataDAC !== monExp) begin
                    mismatched++;
                    $display("FAIL scoreboard: dataDAC=%0d expected %0d", dataDAC, monExp);
                end
            end
        end
    end

    task automatic test_reset();
        modelReset();
        ticks(2);
        compared++;
        if (dataDAC !== 12'd0 || overrun !== 1'b0 || dataUpdated !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: dataDAC=%0d overrun=%b dataUpdated=%b expected 0/0/0", dataDAC, overrun, dataUpdated);
        end
        reset   = 1'b0;
        syncDAC = 1'b1;
        pulseValid(9'd511);
        expQ.push_back(modelPush(9'd511));
        ticks(5);
        adcSample = 9'd100; adcSampleValid = 1'b1;
        tick();
        adcSample = 9'd200;
        tick();
        adcSampleValid = 1'b0;
        expQ.push_back(modelPush(9'd100));
        ticks(5);
        syncDAC = 1'b0;
        pulseValid(9'd50);
        ticks(3);
        compared++;
        if (overrun !== 1'b1 || dataDAC === 12'd0) begin
            mismatched++;
            $display("FAIL pre_reset_state: dataDAC=%0d overrun=%b expected nonzero/1", dataDAC, overrun);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if (dataDAC !== 12'd0 || overrun !== 1'b0 || dataUpdated !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: dataDAC=%0d overrun=%b dataUpdated=%b expected 0/0/0", dataDAC, overrun, dataUpdated);
        end
        modelReset();
        ticks(2);
        reset   = 1'b0;
        syncDAC = 1'b1;
        ticks(6);
        compared++;
        if (dataDAC !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_drops_pending: dataDAC=%0d expected 0", dataDAC);
        end
    endtask

    task automatic test_ramp();
        int lat;
        syncDAC = 1'b1;
        for (int n = 0; n < 8; n++) begin
            pulseValid(9'd511);
            expQ.push_back(modelPush(9'd511));
            lat = -1;
            for (int k = 1; k <= 5; k++) begin
                if (dataUpdated === 1'b1 && lat < 0) lat = k;
                if (k < 5) tick();
            end
            compared++;
            if (lat != 4) begin
                mismatched++;
                $display("FAIL ramp_latency[%0d]: pulse at cycle %0d expected 4", n, lat);
            end
            if (n == 0 || n == 7) begin
                compared++;
                if (dataDAC !== ((n == 0) ? 12'd504 : 12'd4095)) begin
                    mismatched++;
                    $display("FAIL ramp_value[%0d]: dataDAC=%0d expected %0d", n, dataDAC, (n == 0) ? 504 : 4095);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        syncDAC = 1'b1;
        for (int n = 0; n < 8; n++) begin
            pulseValid(9'd256);
            expQ.push_back(modelPush(9'd256));
            ticks(5);
        end
        compared++;
        if (dataDAC !== 12'h804) begin
            mismatched++;
            $display("FAIL wrap_full: dataDAC=0x%h expected 0x804", dataDAC);
        end
        pulseValid(9'd0);
        expQ.push_back(modelPush(9'd0));
        ticks(5);
        compared++;
        if (dataDAC !== 12'h703) begin
            mismatched++;
            $display("FAIL wrap_ninth: dataDAC=0x%h expected 0x703", dataDAC);
        end
    endtask

    task automatic test_frame_hold();
        logic [11:0] prev, e;
        int changes;
        syncDAC = 1'b0;
        prev    = dataDAC;
        changes = 0;
        pulseValid(9'd300);
        e = modelPush(9'd300);
        expQ.push_back(e);
        for (int k = 0; k < 20; k++) begin
            if (dataDAC !== prev || dataUpdated !== 1'b0) changes++;
            tick();
        end
        compared++;
        if (changes != 0) begin
            mismatched++;
            $display("FAIL frame_hold: %0d changes while syncDAC low, expected 0", changes);
        end
        syncDAC = 1'b1;
        tick();
        compared++;
        if (dataUpdated !== 1'b1 || dataDAC !== e) begin
            mismatched++;
            $display("FAIL frame_release: dataDAC=%0d dataUpdated=%b expected %0d/1", dataDAC, dataUpdated, e);
        end
        ticks(2);
    endtask

    task automatic test_overrun();
        syncDAC = 1'b1;
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_idle: overrun=%b expected 0", overrun);
        end
        adcSample = 9'd10; adcSampleValid = 1'b1;
        tick();
        adcSample = 9'd20;
        tick();
        adcSampleValid = 1'b0;
        expQ.push_back(modelPush(9'd10));
        ticks(5);
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_set: overrun=%b expected 1", overrun);
        end
        clearOverrun = 1'b1;
        tick();
        clearOverrun = 1'b0;
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_clear: overrun=%b expected 0", overrun);
        end
        adcSample = 9'd30; adcSampleValid = 1'b1;
        tick();
        adcSample = 9'd40; clearOverrun = 1'b1;
        tick();
        adcSampleValid = 1'b0; clearOverrun = 1'b0;
        expQ.push_back(modelPush(9'd30));
        ticks(5);
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_set_wins: overrun=%b expected 1", overrun);
        end
        clearOverrun = 1'b1;
        tick();
        clearOverrun = 1'b0;
    endtask

    task automatic test_supersede();
        int updates;
        logic [11:0] e;
        syncDAC = 1'b0;
        pulseValid(9'd511);
        void'(modelPush(9'd511));
        ticks(9);
        pulseValid(9'd0);
        expQ.push_back(modelPush(9'd0));
        ticks(4);
        updates = 0;
        syncDAC = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dataUpdated === 1'b1) updates++;
        end
        compared++;
        if (updates != 1) begin
            mismatched++;
            $display("FAIL supersede_single: %0d updates expected 1", updates);
        end
        syncDAC = 1'b0;
        pulseValid(9'd77);
        void'(modelPush(9'd77));
        ticks(4);
        syncDAC = 1'b1;
        adcSample = 9'd88; adcSampleValid = 1'b1;
        tick();
        adcSampleValid = 1'b0;
        compared++;
        if (dataUpdated !== 1'b0) begin
            mismatched++;
            $display("FAIL supersede_sync_collision: dataUpdated=%b expected 0", dataUpdated);
        end
        e = modelPush(9'd88);
        expQ.push_back(e);
        ticks(6);
        compared++;
        if (dataDAC !== e) begin
            mismatched++;
            $display("FAIL supersede_final: dataDAC=%0d expected %0d", dataDAC, e);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_frame_hold();
        test_overrun();
        test_supersede();
        ticks(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d results outstanding expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
